// File: rtl/dpram_pkg.sv
// Shared constants for the single-clock dual-port RAM.
// Build option: DPRAM_OUTREG_EN adds an output pipeline stage (read latency 2).
package dpram_pkg;

`ifdef DPRAM_OUTREG_EN
  localparam int READ_LATENCY = 2;
`else
  localparam int READ_LATENCY = 1;
`endif

  // What a port sees when accesses collide on one address in the same cycle
  typedef enum logic [1:0] {
    OLD_DATA,
    WRITE_THROUGH,
    B_WINS
  } collision_policy_e;

  localparam collision_policy_e SAME_PORT_POLICY  = WRITE_THROUGH;
  localparam collision_policy_e CROSS_PORT_POLICY = OLD_DATA;
  localparam collision_policy_e DUAL_WRITE_POLICY = B_WINS;

endpackage

// File: rtl/dpram_port.sv
// One RAM port: gated write strobe, registered read with write-through.
// Build option: DPRAM_OUTREG_EN adds a second output register stage.
module dpram_port
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] q_stage1;

  // Writes are dropped while reset is high; the array itself is never cleared
  assign mem_we = wren & ~reset;

  // A writing port returns its own data rather than the pre-write contents
  always_ff @(posedge clk) begin
    if (reset) begin
      q_stage1 <= '0;
    end else if (wren) begin
      q_stage1 <= data;
    end else begin
      q_stage1 <= rd_data;
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] q_stage2;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_stage2 <= '0;
    end else begin
      q_stage2 <= q_stage1;
    end
  end

  assign q = q_stage2;
`else
  assign q = q_stage1;
`endif

endmodule

// File: rtl/dpram_1clk.sv
// Single-clock true dual-port RAM; array shared by two dpram_port instances.
// Build option: DPRAM_OUTREG_EN raises read latency from 1 to 2 cycles.
module dpram_1clk
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic                  wren_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  wren_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  mem_we_a;
  logic                  mem_we_b;

  // Reads sample the pre-edge contents, so a cross-port reader gets old data
  assign rd_data_a = mem[address_a];
  assign rd_data_b = mem[address_b];

  // Port B is written last so it wins when both ports hit the same word
  always_ff @(posedge clk) begin
    if (mem_we_a) begin
      mem[address_a] <= data_a;
    end
    if (mem_we_b) begin
      mem[address_b] <= data_b;
    end
  end

  dpram_port #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_port_a (
    .clk    (clk),
    .reset  (reset),
    .wren   (wren_a),
    .data   (data_a),
    .rd_data(rd_data_a),
    .mem_we (mem_we_a),
    .q      (q_a)
  );

  dpram_port #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_port_b (
    .clk    (clk),
    .reset  (reset),
    .wren   (wren_b),
    .data   (data_b),
    .rd_data(rd_data_b),
    .mem_we (mem_we_b),
    .q      (q_b)
  );

endmodule

// File: tb/tb_dpram_1clk.sv
// Bench for dpram_1clk at full framebuffer size (16-bit address, 8-bit data):
// directed collision cases followed by random traffic against a memory model.
module tb_dpram_1clk;
  import dpram_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int LAT   = READ_LATENCY;
  localparam int HIST  = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address_a;
  logic          wren_a;
  logic [DW-1:0] data_a;
  logic [DW-1:0] q_a;
  logic [AW-1:0] address_b;
  logic          wren_b;
  logic [DW-1:0] data_b;
  logic [DW-1:0] q_b;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] pipe_a [LAT];
  logic [DW-1:0] pipe_b [LAT];
  logic [DW-1:0] obs_a [HIST];
  logic [DW-1:0] obs_b [HIST];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit model_live = 1'b0;

  always #5 clk = ~clk;

  dpram_1clk #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address_a(address_a),
    .wren_a   (wren_a),
    .data_a   (data_a),
    .q_a      (q_a),
    .address_b(address_b),
    .wren_b   (wren_b),
    .data_b   (data_b),
    .q_b      (q_b)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, observed, expected);
    end
  endtask

  // Drives one cycle, advances the reference model, then checks both outputs
  task automatic applyStimulus(input logic rst,
                               input logic [AW-1:0] aa, input logic wa, input logic [DW-1:0] da,
                               input logic [AW-1:0] ab, input logic wb, input logic [DW-1:0] db);
    logic [DW-1:0] new_a;
    logic [DW-1:0] new_b;
    @(negedge clk);
    reset     = rst;
    address_a = aa;
    wren_a    = wa;
    data_a    = da;
    address_b = ab;
    wren_b    = wb;
    data_b    = db;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_a[i] = '0;
        pipe_b[i] = '0;
      end
      model_live = 1'b1;
    end else begin
      new_a = wa ? da : ref_mem[aa];
      new_b = wb ? db : ref_mem[ab];
      if (wa) ref_mem[aa] = da;
      if (wb) ref_mem[ab] = db;
      for (int i = LAT - 1; i > 0; i--) begin
        pipe_a[i] = pipe_a[i-1];
        pipe_b[i] = pipe_b[i-1];
      end
      pipe_a[0] = new_a;
      pipe_b[0] = new_b;
    end
    #1;
    if (cyc < HIST) begin
      obs_a[cyc] = q_a;
      obs_b[cyc] = q_b;
    end
    if (model_live) begin
      checkOutput("model_q_a", q_a, pipe_a[LAT-1]);
      checkOutput("model_q_b", q_b, pipe_b[LAT-1]);
    end
    cyc++;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    int c_rst, c_rd10, c_rd03, c_wt, c_x, c_dw, c_r1, c_r2;
    logic          r_rst;
    logic [AW-1:0] r_aa, r_ab;
    logic          r_wa, r_wb;
    logic [DW-1:0] r_da, r_db;

    reset     = 1'b1;
    address_a = '0;
    wren_a    = 1'b0;
    data_a    = '0;
    address_b = '0;
    wren_b    = 1'b0;
    data_b    = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset with a pending write that must be dropped
    applyStimulus(1'b1, 16'h0010, 1'b1, 8'hAA, 16'h0000, 1'b0, 8'h00);
    applyStimulus(1'b1, 16'h0010, 1'b1, 8'hAA, 16'h0000, 1'b0, 8'h00);
    c_rst = cyc - 1;
    applyStimulus(1'b0, 16'h0010, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    c_rd10 = cyc - 1;

    applyStimulus(1'b0, 16'h0003, 1'b1, 8'h5A, 16'h0000, 1'b0, 8'h00);
    applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 16'h0003, 1'b0, 8'h00);
    c_rd03 = cyc - 1;

    applyStimulus(1'b0, 16'h0020, 1'b1, 8'hC3, 16'h0000, 1'b0, 8'h00);
    c_wt = cyc - 1;

    applyStimulus(1'b0, 16'h0040, 1'b1, 8'h11, 16'h0000, 1'b0, 8'h00);
    applyStimulus(1'b0, 16'h0040, 1'b1, 8'h22, 16'h0040, 1'b0, 8'h00);
    c_x = cyc - 1;
    applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 16'h0040, 1'b0, 8'h00);

    applyStimulus(1'b0, 16'h007F, 1'b1, 8'h01, 16'h007F, 1'b1, 8'h02);
    c_dw = cyc - 1;
    applyStimulus(1'b0, 16'h007F, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);

    applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 16'hFFFF, 1'b1, 8'hFF);
    applyStimulus(1'b0, 16'hFFFF, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    c_r1 = cyc - 1;
    applyStimulus(1'b0, 16'hFFFF, 1'b1, 8'hFE, 16'h0000, 1'b0, 8'h00);
    applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 16'hFFFF, 1'b0, 8'h00);
    c_r2 = cyc - 1;
    repeat (LAT + 1) idleCycle();

    checkOutput("reset_q_a", obs_a[c_rst], 8'h00);
    checkOutput("reset_q_b", obs_b[c_rst], 8'h00);
    checkOutput("reset_write_dropped", obs_a[c_rd10 + LAT - 1], 8'h00);
    checkOutput("basic_read_b", obs_b[c_rd03 + LAT - 1], 8'h5A);
    checkOutput("write_through_a", obs_a[c_wt + LAT - 1], 8'hC3);
    checkOutput("cross_port_old", obs_b[c_x + LAT - 1], 8'h11);
    checkOutput("cross_port_new", obs_b[c_x + LAT], 8'h22);
    checkOutput("dual_write_q_a", obs_a[c_dw + LAT - 1], 8'h01);
    checkOutput("dual_write_q_b", obs_b[c_dw + LAT - 1], 8'h02);
    checkOutput("dual_write_b_wins", obs_a[c_dw + LAT], 8'h02);
    checkOutput("rmw_read_top", obs_a[c_r1 + LAT - 1], 8'hFF);
    checkOutput("rmw_readback", obs_b[c_r2 + LAT - 1], 8'hFE);
    checkOutput("addr0_untouched", obs_a[c_r2 + LAT - 1], 8'h00);

    // Random traffic concentrated on a few addresses to provoke collisions
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 49) == 0);
      r_aa  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      r_ab  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) r_ab = 16'hFFFF;
      r_wa  = $urandom_range(0, 1) == 1;
      r_wb  = $urandom_range(0, 1) == 1;
      r_da  = DW'($urandom);
      r_db  = DW'($urandom);
      applyStimulus(r_rst, r_aa, r_wa, r_da, r_ab, r_wb, r_db);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpram_1clk.md
Name: dpram_1clk

Overview:
- Single-clock true dual-port synchronous RAM; two independent read/write ports (A, B) share one storage array.
- Generic storage primitive for system blocks: CPU-facing register/vector RAM on port A, video/renderer engines on port B, including 64 KiB framebuffers with read-modify-write on one port.
- Infers block RAM; registered read data.

Parameters:
- ADDR_WIDTH, default 8, address bits per port; depth = 2**ADDR_WIDTH words. Positional parameter 1.
- DATA_WIDTH, default 8, bits per word. Positional parameter 2.

Ports:
- clk  input  1  single clock; all activity on rising edge
- reset  input  1  synchronous, active-high
- address_a  input  ADDR_WIDTH  port A word address
- wren_a  input  1  port A write enable
- data_a  input  DATA_WIDTH  port A write data
- q_a  output  DATA_WIDTH  port A registered read data
- address_b  input  ADDR_WIDTH  port B word address
- wren_b  input  1  port B write enable
- data_b  input  DATA_WIDTH  port B write data
- q_b  output  DATA_WIDTH  port B registered read data

Behaviour:
- Memory powers up all-zero (initial contents 0); reset never clears the array.
- Reset: while reset=1 at a clock edge, q_a and q_b become 0 and both writes are suppressed. Reset value of q_a and q_b is 0.
- Read: each port reads every cycle, with no read enable. q_x updates at the edge after address_x is presented (latency 1) and holds until the next edge.
- Write: wren_x=1 at an edge stores data_x at address_x. The data is visible to any read issued on a later edge.
- Same-port read-during-write: write-through. q_x takes data_x on the write edge.
- Cross-port, same address, A writes while B reads (or vice versa): the reading port returns the old contents. The new value is visible from the next edge.
- Both ports write the same address on the same edge: port B's data is stored. Each port's q shows its own written data (write-through).
- Different addresses: the ports are fully independent, with no stalls or wait states.
- Addresses use the full width with no wrap logic needed. Address 2**ADDR_WIDTH-1 is valid.
- wren inputs must be driven. Integrators tie unused write ports to 0 and unused data to 0.
- No handshake: every cycle is accepted on both ports.

Optional Feature:
- Macro DPRAM_OUTREG_EN.
- When defined: an extra output pipeline register on q_a and q_b. Read latency becomes 2 cycles, and write-through data also appears 2 cycles after the write edge. Reset also clears the second stage to 0.
- When undefined: latency 1 as above.

Decomposition:
- Shared package dpram_pkg:
  - constant READ_LATENCY (1, or 2 under DPRAM_OUTREG_EN)
  - enum of collision policy {OLD_DATA, WRITE_THROUGH, B_WINS} for documentation and bench checks.
- Sub-module dpram_port is natural: one port's write/read/write-through/optional-outreg logic, instantiated twice around the shared array. The array itself stays in the top.

Test Plan:
- Reset: assert reset 2 cycles with wren_a=1, data_a=8'hAA, address_a=0x10 -> q_a=q_b=0. Later read of 0x10 returns 0x00, because the write was suppressed.
- Basic write/read: A writes 0x5A to 0x03. Next cycle B reads 0x03 -> q_b=0x5A exactly 1 cycle after the address (2 cycles with DPRAM_OUTREG_EN).
- Write-through: A writes 0xC3 to 0x20 with address_a=0x20 -> q_a=0xC3 on the same edge's output.
- Cross-port collision: 0x40 holds 0x11. A writes 0x22 to 0x40 while B reads 0x40 -> q_b=0x11. Next cycle q_b=0x22.
- Dual-write collision: A writes 0x01 and B writes 0x02 to 0x7F on the same edge -> q_a=0x01, q_b=0x02. A subsequent read returns 0x02.
- Read-modify-write at full size (ADDR_WIDTH=16): B writes 0xFF to 0xFFFF. A reads 0xFFFF -> 0xFF. A writes 0xFE (value<<1) to 0xFFFF. B reads -> 0xFE. Address 0x0000 is unaffected and stays 0x00.
